// File: rtl/pkg_salsa.sv
// Shared Salsa20 constants and the keystream-consumer types.
// Also holds the state encoding for salsa20_stream_xor.
package pkg_salsa;
    // "expand 32-byte k" / "expand 16-byte k", word 0 first
    localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    localparam logic [3:0][31:0] TAU   = {32'h6b206574, 32'h79622d36, 32'h3120646e, 32'h61707865};

    localparam int KS_BYTES = 64;
    localparam int IDX_W    = $clog2(KS_BYTES);

    typedef logic [0:KS_BYTES-1][7:0] ks_block_t;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, STREAM} state_t;
endpackage

// File: rtl/salsa20_stream_xor_if.sv
// Generator request/result and byte-stream handshake bundle.
// slave = the XOR block, master = generator plus stream source/sink.
interface salsa20_stream_xor_if
    import pkg_salsa::*;
#(parameter int BLK_W = 64);
    logic             ks_start;
    logic [BLK_W-1:0] ks_blkid;
    logic             ks_valid;
    ks_block_t        ks_block;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;

    modport slave (
        output ks_start, ks_blkid, in_ready, out_valid, out_data, out_last,
        input  ks_valid, ks_block, in_valid, in_data, in_last, out_ready
    );
    modport master (
        input  ks_start, ks_blkid, in_ready, out_valid, out_data, out_last,
        output ks_valid, ks_block, in_valid, in_data, in_last, out_ready
    );
endinterface

// File: rtl/salsa20_ks_buffer.sv
// One captured keystream block and its read index.
// The byte storage is deliberately not reset; only the index is.
module salsa20_ks_buffer
    import pkg_salsa::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load,
    input  logic      adv,
    input  ks_block_t blk,
    output logic [7:0] rd_byte,
    output logic      at_last
);
    ks_block_t        mem;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (load) mem <= blk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       idx <= '0;
        else if (load) idx <= '0;
        else if (adv)  idx <= idx + IDX_W'(1);
    end

    assign rd_byte = mem[idx];
    assign at_last = (idx == IDX_W'(KS_BYTES - 1));
endmodule

// File: rtl/salsa20_stream_xor.sv
// Salsa20 keystream consumer: requests blocks from the generator and XORs
// them byte by byte onto a valid/ready stream (encrypt == decrypt).
module salsa20_stream_xor
    import pkg_salsa::*;
#(
    parameter int BLK_W    = 64,
    parameter int KS_BYTES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init,
    input  logic [BLK_W-1:0]     init_blkid,
    output logic                 busy,
    output logic                 ctr_wrap,
    salsa20_stream_xor_if.slave  bus
);
    if (KS_BYTES != 64) begin : g_bad_cfg
        $error("salsa20_stream_xor: KS_BYTES must be 64");
    end

    state_t           state;
    logic [BLK_W-1:0] ctr;
    logic             hs, buf_load, at_last;
    logic [7:0]       ks_byte;

    // init aborts the block, so no byte may be accepted in the same cycle
    assign bus.in_ready = (state == STREAM) && !init && (!bus.out_valid || bus.out_ready);
    assign hs           = bus.in_valid && bus.in_ready;
    // withholding start under init keeps a restart from REQ at one request in flight
    assign bus.ks_start = (state == REQ) && !init;
    assign busy         = (state != IDLE);
    assign buf_load     = (state == WAIT) && bus.ks_valid && !init;

    salsa20_ks_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .adv     (hs),
        .blk     (bus.ks_block),
        .rd_byte (ks_byte),
        .at_last (at_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ctr           <= '0;
            bus.ks_blkid  <= '0;
            ctr_wrap      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (hs) begin
                bus.out_data  <= bus.in_data ^ ks_byte;
                bus.out_last  <= bus.in_last;
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (init) begin
                ctr      <= init_blkid;
                ctr_wrap <= 1'b0;
                // a request is outstanding in WAIT/DRAIN: swallow its result first
                if (state == WAIT || state == DRAIN) begin
                    state <= DRAIN;
                end else begin
                    bus.ks_blkid  <= init_blkid;
                    bus.out_valid <= 1'b0;
                    state         <= REQ;
                end
            end else begin
                case (state)
                    IDLE: ;
                    REQ:  state <= WAIT;
                    WAIT: if (bus.ks_valid) begin
                        ctr          <= ctr + BLK_W'(1);
                        bus.ks_blkid <= ctr + BLK_W'(1);
                        if (&ctr) ctr_wrap <= 1'b1;
                        state        <= STREAM;
                    end
                    DRAIN: if (bus.ks_valid) begin
                        bus.ks_blkid <= ctr;
                        state        <= REQ;
                    end
                    STREAM: if (hs && at_last) state <= REQ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_salsa20_stream_xor.sv
// Directed bench for salsa20_stream_xor with a behavioural keystream generator.
module tb_salsa20_stream_xor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init = 1'b0;
    logic [63:0] init_blkid = '0;
    logic        busy, ctr_wrap;

    salsa20_stream_xor_if #(.BLK_W(64)) bus ();

    salsa20_stream_xor #(.BLK_W(64), .KS_BYTES(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .init_blkid (init_blkid),
        .busy       (busy),
        .ctr_wrap   (ctr_wrap),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  oq[$];
    logic        lq[$];
    logic [63:0] sq[$];
    logic [7:0]  fill_q[$];
    int          ks_mode = 0;
    int          ks_delay = 3;
    logic [7:0]  ks_fill = 8'hA5;
    int          bp_en = 0;
    logic [3:0]  bp_pat = 4'b1001;
    logic [7:0]  ct[100];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] kf(input logic [63:0] b, input int i);
        return b[7:0] * 8'h1D + 8'(i) * 8'h07 + 8'h3C;
    endfunction

    function automatic logic [7:0] pt(input int n);
        return 8'(n * 3 + 7);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [63:0] b);
        init = 1'b1;
        init_blkid = b;
        @(posedge clk); #1;
        init = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 400);
        chk("send_rdy", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // keystream generator model: result a few cycles after start, held until next start
    initial begin
        int          cnt = 0;
        logic [7:0]  f;
        logic [0:63][7:0] pend;
        bus.ks_valid = 1'b0;
        bus.ks_block = '0;
        pend = '0;
        forever begin
            @(negedge clk);
            if (bus.ks_start) begin
                sq.push_back(bus.ks_blkid);
                bus.ks_valid = 1'b0;
                cnt = ks_delay;
                f = ks_fill;
                if (ks_mode == 2 && fill_q.size() > 0) f = fill_q.pop_front();
                for (int i = 0; i < 64; i++) pend[i] = (ks_mode == 1) ? kf(bus.ks_blkid, i) : f;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.ks_valid = 1'b1;
                    bus.ks_block = pend;
                end
            end
        end
    end

    initial begin
        int k = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (bp_en != 0) begin
                bus.out_ready = bp_pat[k % 4];
                k++;
            end else begin
                bus.out_ready = 1'b1;
                k = 0;
            end
        end
    end

    // output capture, 1-cycle latency and stall-hold checks
    initial begin
        logic       prev_hs = 1'b0, prev_stall = 1'b0, hold_l = 1'b0;
        logic [7:0] hold_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (prev_hs) chk("latency", 64'(bus.out_valid), 64'd1);
                if (prev_stall && bus.out_valid) begin
                    chk("hold_data", 64'(bus.out_data), 64'(hold_d));
                    chk("hold_last", 64'(bus.out_last), 64'(hold_l));
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                oq.push_back(bus.out_data);
                lq.push_back(bus.out_last);
            end
            prev_hs    = bus.in_valid && bus.in_ready && !rst;
            prev_stall = bus.out_valid && !bus.out_ready && !rst;
            hold_d     = bus.out_data;
            hold_l     = bus.out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;

        // reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_ks_start", 64'(bus.ks_start), 0);
        chk("rst_ks_blkid", bus.ks_blkid, 0);
        chk("rst_in_ready", 64'(bus.in_ready), 0);
        chk("rst_out_valid", 64'(bus.out_valid), 0);
        chk("rst_out_data", 64'(bus.out_data), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ctr_wrap", 64'(ctr_wrap), 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        cyc(2);
        chk("idle_busy", 64'(busy), 0);

        // basic block: 0xA5 fill, 64 bytes, then request for block 1
        ks_mode = 0; ks_fill = 8'hA5;
        sq.delete(); oq.delete(); lq.delete();
        do_init(64'd0);
        chk("t1_busy", 64'(busy), 1);
        chk("t1_rdy_req", 64'(bus.in_ready), 0);
        cyc(1);
        chk("t1_rdy_wait", 64'(bus.in_ready), 0);
        for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
        chk("t1_start2", 64'(bus.ks_start), 1);
        chk("t1_blkid2", bus.ks_blkid, 64'd1);
        chk("t1_rdy_after63", 64'(bus.in_ready), 0);
        cyc(10);
        chk("t1_count", 64'(oq.size()), 64'd64);
        for (int i = 0; i < 64; i++) chk("t1_data", 64'(oq[i]), 64'(8'hA5 ^ 8'(i)));
        chk("t1_nstart", 64'(sq.size()), 64'd2);
        chk("t1_sq0", sq[0], 64'd0);
        chk("t1_sq1", sq[1], 64'd1);

        // round trip over a block boundary
        ks_mode = 1;
        sq.delete(); oq.delete(); lq.delete();
        do_init(64'd0);
        for (int n = 0; n < 100; n++) send_byte(pt(n), n == 99);
        cyc(10);
        chk("t2_enc_count", 64'(oq.size()), 64'd100);
        for (int n = 0; n < 100; n++) begin
            ct[n] = oq[n];
            chk("t2_enc", 64'(oq[n]), 64'(pt(n) ^ kf(64'(n / 64), n % 64)));
        end
        chk("t2_enc_last", 64'(lq[99]), 64'd1);
        chk("t2_enc_sq", 64'(sq.size()), 64'd2);
        chk("t2_enc_sq1", sq[1], 64'd1);
        sq.delete(); oq.delete(); lq.delete();
        do_init(64'd0);
        for (int n = 0; n < 100; n++) send_byte(ct[n], 1'b0);
        cyc(10);
        chk("t2_dec_count", 64'(oq.size()), 64'd100);
        for (int n = 0; n < 100; n++) chk("t2_dec", 64'(oq[n]), 64'(pt(n)));
        chk("t2_dec_sq0", sq[0], 64'd0);
        chk("t2_dec_sq1", sq[1], 64'd1);

        // backpressure 1,0,0,1
        ks_mode = 0; ks_fill = 8'h3C;
        sq.delete(); oq.delete(); lq.delete();
        do_init(64'd0);
        cyc(8);
        bp_en = 1;
        for (int i = 0; i < 20; i++) send_byte(8'(i + 8'h40), i == 19);
        cyc(6);
        bp_en = 0;
        cyc(4);
        chk("t3_count", 64'(oq.size()), 64'd20);
        for (int i = 0; i < 20; i++) begin
            chk("t3_data", 64'(oq[i]), 64'(8'(i + 8'h40) ^ 8'h3C));
            chk("t3_last", 64'(lq[i]), 64'(i == 19));
        end

        // counter wrap
        ks_mode = 1;
        sq.delete(); oq.delete(); lq.delete();
        do_init(64'hFFFF_FFFF_FFFF_FFFF);
        send_byte(8'h00, 1'b0);
        chk("t4_wrap_set", 64'(ctr_wrap), 1);
        for (int i = 1; i < 65; i++) send_byte(8'h00, 1'b0);
        cyc(6);
        chk("t4_nstart", 64'(sq.size()), 64'd2);
        chk("t4_sq0", sq[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4_sq1", sq[1], 64'd0);
        chk("t4_b63", 64'(oq[63]), 64'(kf(64'hFF, 63)));
        chk("t4_b64", 64'(oq[64]), 64'(kf(64'd0, 0)));
        do_init(64'd3);
        chk("t4_wrap_clr", 64'(ctr_wrap), 0);
        cyc(12);

        // init while a request is pending: 0x11 block discarded, 0x22 used
        ks_mode = 2; ks_delay = 6;
        fill_q.delete(); fill_q.push_back(8'h11); fill_q.push_back(8'h22);
        sq.delete(); oq.delete(); lq.delete();
        do_init(64'd0);
        cyc(1);
        do_init(64'd5);
        chk("t5_drain_busy", 64'(busy), 1);
        chk("t5_drain_rdy", 64'(bus.in_ready), 0);
        chk("t5_blkid_hold", bus.ks_blkid, 64'd0);
        cyc(25);
        chk("t5_nstart", 64'(sq.size()), 64'd2);
        chk("t5_sq0", sq[0], 64'd0);
        chk("t5_sq1", sq[1], 64'd5);
        for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b0);
        cyc(4);
        chk("t5_count", 64'(oq.size()), 64'd10);
        for (int i = 0; i < 10; i++) chk("t5_data", 64'(oq[i]), 64'(8'h22 ^ 8'(i)));
        ks_delay = 3;

        // reset mid-stream with an output byte pending
        ks_mode = 0; ks_fill = 8'h77;
        oq.delete(); lq.delete();
        do_init(64'd0);
        cyc(8);
        for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b0);
        chk("t6_pending", 64'(bus.out_valid), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_out_valid", 64'(bus.out_valid), 0);
        chk("t6_out_data", 64'(bus.out_data), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_in_ready", 64'(bus.in_ready), 0);
        chk("t6_ks_start", 64'(bus.ks_start), 0);
        chk("t6_blkid", bus.ks_blkid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        n0 = sq.size();
        cyc(8);
        chk("t6_no_start", 64'(sq.size()), 64'(n0));
        chk("t6_idle", 64'(busy), 0);
        do_init(64'd9);
        cyc(3);
        chk("t6_restart", 64'(sq.size()), 64'(n0 + 1));
        chk("t6_restart_id", sq[sq.size() - 1], 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/salsa20_stream_xor.md
Name: salsa20_stream_xor

Overview:
- Consumer side of the Salsa20 keystream generator. It drives the generator's start/block-id inputs and reads back each 64-byte keystream block.
- It XORs the keystream, byte by byte, onto a valid/ready byte stream. The operation is the same for encrypt and decrypt.
- It sits between the keystream generator instance and the byte-stream datapath, and owns block-counter sequencing.

Parameters:
- BLK_W, 64, width of the Salsa20 block counter (blkid).
- KS_BYTES, 64, keystream bytes per block. Fixed at 64; any other value is a configuration error.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- init  in  1  one-cycle pulse: latch init_blkid, abort the current block, restart keystream
- init_blkid  in  BLK_W  first block counter value after init
- ks_start  out  1  one-cycle request pulse to the keystream generator
- ks_blkid  out  BLK_W  block id for the request; stable from ks_start until ks_valid
- ks_valid  in  1  generator result valid (level)
- ks_block  in  8 x [0:63]  keystream bytes; byte 0 is applied first
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid && in_ready
- in_data  in  8  plaintext or ciphertext byte
- in_last  in  1  end-of-message marker, passed through unchanged
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts the output byte
- out_data  out  8  in_data XOR keystream byte
- out_last  out  1  registered copy of in_last
- busy  out  1  high in any state other than IDLE
- ctr_wrap  out  1  sticky flag: block counter wrapped from all-ones to 0; cleared only by init or rst

Behaviour:
- Reset values:
  - Outputs: every output is 0.
  - Internal: state=IDLE, byte index=0, block counter=0.
  - Buffer: the keystream buffer is not reset.
- States are IDLE, REQ, WAIT, DRAIN and STREAM.
- IDLE: in_ready=0. init moves to REQ.
- REQ:
  - Assert ks_start for exactly 1 cycle.
  - Drive ks_blkid from the block counter.
  - Next state is WAIT.
- WAIT:
  - On the first cycle with ks_valid=1, capture all 64 bytes of ks_block.
  - Set byte index=0 and block counter += 1, modulo 2^BLK_W. On the all-ones to 0 transition, set ctr_wrap.
  - Next state is STREAM.
  - ks_start is never asserted in WAIT.
- STREAM:
  - in_ready = !out_valid || out_ready.
  - On an input handshake: out_data <= in_data ^ buf[idx], out_last <= in_last, out_valid <= 1, idx += 1.
  - Latency from input accept to out_valid is 1 cycle.
  - Full-rate throughput is 1 byte/cycle when out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_last hold and in_ready=0. out_valid clears on out_ready when no new byte is accepted.
- Block exhaustion: accepting the byte at idx=63 moves to REQ. in_ready stays 0 through REQ and WAIT. The already-registered output byte still drains normally.
- in_last does not realign the keystream. The next message continues at the next keystream byte; a new message needs init to restart.
- init with priority over everything except rst:
  - In IDLE, REQ or STREAM: latch init_blkid, clear ctr_wrap and out_valid, go to REQ on the next cycle.
  - In WAIT: latch init_blkid and clear ctr_wrap, then go to DRAIN. DRAIN waits for ks_valid, discards that block (no capture, no counter increment), then goes to REQ.
  - init in DRAIN re-latches init_blkid and stays in DRAIN.
- The generator is never given a second start while a request is in flight.
- rst mid-operation returns immediately to the reset values. Any in-flight generator result is ignored, because ks_valid is only sampled in WAIT and DRAIN.
- ks_valid seen in IDLE, REQ or STREAM is ignored.

Decomposition:
- Put the state enum (IDLE, REQ, WAIT, DRAIN, STREAM) and KS_BYTES in pkg_salsa, next to SIGMA/TAU.
- One natural sub-module: salsa20_ks_buffer. It is the 64-byte capture register plus a 6-bit read index, with load, advance and index==63 flag.
- The FSM and output register stay in the top module. The keystream generator is instantiated by the parent, not inside this block.

Test Plan:
- Basic block: init with init_blkid=0, bench model returns ks_block[i]=0xA5, send in_data=i for i=0..63 with no backpressure. Expect:
  - out_data=0xA5^i, 1-cycle latency.
  - A second ks_start with ks_blkid=1 after byte 63.
  - in_ready=0 until ks_valid.
- Round trip: encrypt 100 bytes with block-dependent bench keystream, then init the same blkid and feed the ciphertext back. Expect the original bytes, with a block boundary at byte 64 and ks_blkid sequence 0,1.
- Backpressure: out_ready toggles 1,0,0,1 during STREAM. Expect:
  - out_data and out_last stable while stalled.
  - No byte lost or duplicated.
  - Index advances only on a handshake.
- Counter wrap: init_blkid=0xFFFF_FFFF_FFFF_FFFF, stream 65 bytes. Expect:
  - ks_blkid sequence FFFF_FFFF_FFFF_FFFF then 0.
  - ctr_wrap=1 after the first capture.
  - ctr_wrap cleared by the next init.
- init during WAIT: assert init with init_blkid=5 while the ks_blkid=0 request is pending; generator returns 0x11-filled, then 0x22-filled. Expect:
  - The 0x11 block is discarded.
  - The next ks_start has ks_blkid=5.
  - Outputs use 0x22.
- Reset mid-stream: assert rst after 10 bytes, with out_valid=1 pending. Expect all outputs 0 asynchronously, state IDLE, no ks_start until the next init.
